// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge port used by the fetch stage.
interface fetch_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            ImemReq;
  logic [XLEN-1:0] ImemAddr;
  logic            ImemAck;
  logic [XLEN-1:0] ImemRdata;

  modport master (output ImemReq, ImemAddr, input ImemAck, ImemRdata);
  modport slave  (input ImemReq, ImemAddr, output ImemAck, ImemRdata);
endinterface

// File: rtl/fetch_stage.sv
// RV32I IF stage plus IF/ID register over a variable-latency req/ack imem port.
// Optional macro FETCH_PERF_EN adds bubble and discarded-transfer counters.
module fetch_stage #(
  parameter int unsigned    XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  fetch_stage_if.master   imem,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     BubbleCntD,
  output logic [31:0]     DiscardCnt
`endif
);

  localparam logic [1:0] S_FETCH   = 2'b00;
  localparam logic [1:0] S_HOLD    = 2'b01;
  localparam logic [1:0] S_DISCARD = 2'b10;

  localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [1:0]      state, state_n;
  logic [XLEN-1:0] pcf, pcf_n;
  logic [XLEN-1:0] redir, redir_n;
  logic [XLEN-1:0] buffer, buffer_n;
  logic [XLEN-1:0] pcf_plus4;
  logic [XLEN-1:0] avail_instr;
  logic            xfer;
  logic            avail;

  assign imem.ImemReq  = !reset && (state != S_HOLD);
  assign imem.ImemAddr = pcf;

  assign xfer        = imem.ImemReq && imem.ImemAck;
  assign avail       = ((state == S_FETCH) && xfer) || (state == S_HOLD);
  assign avail_instr = (state == S_HOLD) ? buffer : imem.ImemRdata;
  assign pcf_plus4   = pcf + PC_STEP;

  // Next-state: a redirect from E always outranks stall handling.
  always_comb begin
    state_n  = state;
    pcf_n    = pcf;
    redir_n  = redir;
    buffer_n = buffer;
    case (state)
      S_FETCH: begin
        if (PCSrcE) begin
          if (xfer) begin
            pcf_n = PCTargetE;
          end else begin
            redir_n = PCTargetE;
            state_n = S_DISCARD;
          end
        end else if (xfer) begin
          if (StallF) begin
            buffer_n = imem.ImemRdata;
            state_n  = S_HOLD;
          end else begin
            pcf_n = pcf_plus4;
          end
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          pcf_n   = PCTargetE;
          state_n = S_FETCH;
        end else if (!StallF) begin
          pcf_n   = pcf_plus4;
          state_n = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (PCSrcE) begin
          redir_n = PCTargetE;
          if (xfer) begin
            pcf_n   = PCTargetE;
            state_n = S_FETCH;
          end
        end else if (xfer) begin
          pcf_n   = redir;
          state_n = S_FETCH;
        end
      end
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_FETCH;
      pcf    <= RESET_PC;
      redir  <= '0;
      buffer <= '0;
    end else begin
      state  <= state_n;
      pcf    <= pcf_n;
      redir  <= redir_n;
      buffer <= buffer_n;
    end
  end

  // IF/ID register: flush beats stall beats load.
  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      if (avail && !PCSrcE) begin
        InstrD   <= avail_instr;
        PCD      <= pcf;
        PCPlus4D <= pcf_plus4;
        ValidD   <= 1'b1;
      end else begin
        InstrD   <= NOP;
        PCD      <= '0;
        PCPlus4D <= '0;
        ValidD   <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic bubble_inc;
  logic discard_inc;

  assign bubble_inc  = !FlushD && !StallD && !avail;
  assign discard_inc = xfer && ((state == S_DISCARD) || ((state == S_FETCH) && PCSrcE));

  always_ff @(posedge clk) begin
    if (reset) begin
      BubbleCntD <= '0;
      DiscardCnt <= '0;
    end else begin
      if (bubble_inc)  BubbleCntD <= BubbleCntD + 32'd1;
      if (discard_inc) DiscardCnt <= DiscardCnt + 32'd1;
    end
  end
`endif

endmodule
